// File: rtl/vedic_mult_8x8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// vedic_mult_8x8_seq_ctrl
//
// Computes an 8x8 -> 16-bit product by time-sharing one external 4x4
// combinational or pipelined multiplier over four nibble partial products.
// The partial products are shifted and accumulated into a 16-bit register.
//
// Configuration macro: VEDIC_SEQ_SIGNED_EN
//   - defined:   in_a/in_b are two's complement. Magnitudes are multiplied and
//                the sign is applied to the final sum.
//   - undefined: operands are unsigned and no sign logic is built.
//
// Parameter:
//   MUL_LAT  extra cycles to wait after driving mul_a/mul_b before mul_p is
//            sampled. 0 means mul_p is sampled in the same cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operand pair valid      | in_ready  high only in IDLE
//   in_a/in_b  8-bit operands
//   out_valid  result valid, held until out_ready
//   out_ready  sink accepts result
//   out_p      16-bit product
//   busy       high in any state other than IDLE
//   mul_a/b    nibble operands to the shared 4x4 multiplier (0 outside MUL)
//   mul_p      8-bit product from the shared multiplier
//   dbg_state  current FSM state (0 IDLE, 1 MUL, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. valid, once raised, is held with stable data until that edge.
// ready may depend on state only, never on valid.
// -----------------------------------------------------------------------------
module vedic_mult_8x8_seq_ctrl #(
  parameter int unsigned MUL_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy,
  output logic [3:0]  mul_a,
  output logic [3:0]  mul_b,
  input  logic [7:0]  mul_p,
  output logic [1:0]  dbg_state
);

  localparam int WW = (MUL_LAT > 0) ? $clog2(MUL_LAT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      a_q, a_d;
  logic [7:0]      b_q, b_d;
  logic [15:0]     acc_q, acc_d;
  logic [1:0]      step_q, step_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [15:0]     out_p_q, out_p_d;
  logic [15:0]     partial;
  logic [15:0]     acc_sum;
  logic [15:0]     final_p;
  logic [7:0]      a_in_mag;
  logic [7:0]      b_in_mag;

`ifdef VEDIC_SEQ_SIGNED_EN
  logic sign_q, sign_d;

  // -128 maps to magnitude 128, which still fits in 8 unsigned bits.
  assign a_in_mag = in_a[7] ? (~in_a + 8'd1) : in_a;
  assign b_in_mag = in_b[7] ? (~in_b + 8'd1) : in_b;
  assign final_p  = sign_q ? (~acc_sum + 16'd1) : acc_sum;
`else
  assign a_in_mag = in_a;
  assign b_in_mag = in_b;
  assign final_p  = acc_sum;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    step_d  = step_q;
    wait_d  = wait_q;
    out_p_d = out_p_q;
    mul_a   = 4'd0;
    mul_b   = 4'd0;
    partial = 16'd0;
    acc_sum = acc_q;
`ifdef VEDIC_SEQ_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a_in_mag;
          b_d     = b_in_mag;
`ifdef VEDIC_SEQ_SIGNED_EN
          sign_d  = in_a[7] ^ in_b[7];
`endif
          acc_d   = 16'd0;
          step_d  = 2'd0;
          wait_d  = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // step bit0 selects the high nibble of a, bit1 the high nibble of b:
        // 0: lo*lo, 1: hi*lo, 2: lo*hi, 3: hi*hi.
        mul_a = step_q[0] ? a_q[7:4] : a_q[3:0];
        mul_b = step_q[1] ? b_q[7:4] : b_q[3:0];
        case (step_q)
          2'd0:    partial = {8'h00, mul_p};
          2'd1,
          2'd2:    partial = {4'h0, mul_p, 4'h0};
          default: partial = {mul_p, 8'h00};
        endcase
        acc_sum = acc_q + partial;
        if (wait_q == WW'(MUL_LAT)) begin
          wait_d = '0;
          acc_d  = acc_sum;
          step_d = step_q + 2'd1;
          if (step_q == 2'd3) begin
            out_p_d = final_p;
            state_d = S_DONE;
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 16'd0;
      step_q  <= 2'd0;
      wait_q  <= '0;
      out_p_q <= 16'd0;
`ifdef VEDIC_SEQ_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      wait_q  <= wait_d;
      out_p_q <= out_p_d;
`ifdef VEDIC_SEQ_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_p     = out_p_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vedic_mult_8x8_seq_ctrl.sv
module tb_vedic_mult_8x8_seq_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 0: MUL_LAT = 0, combinational multiplier ----------------
  logic        in_valid0 = 1'b0, out_ready0 = 1'b1;
  logic [7:0]  in_a0 = 8'd0, in_b0 = 8'd0;
  logic        in_ready0, out_valid0, busy0;
  logic [15:0] out_p0;
  logic [3:0]  mul_a0, mul_b0;
  logic [7:0]  mul_p0;
  logic [1:0]  dbg0;

  assign mul_p0 = {4'h0, mul_a0} * {4'h0, mul_b0};

  vedic_mult_8x8_seq_ctrl #(.MUL_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_p(out_p0),
    .busy(busy0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0),
    .dbg_state(dbg0)
  );

  // ---------------- DUT 1: MUL_LAT = 2, two-stage pipelined multiplier ----------------
  logic        in_valid1 = 1'b0;
  logic [7:0]  in_a1 = 8'd0, in_b1 = 8'd0;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] out_p1;
  logic [3:0]  mul_a1, mul_b1;
  logic [7:0]  mul_p1, pipe1;
  logic [1:0]  dbg1;

  always @(posedge clk) begin
    pipe1  <= {4'h0, mul_a1} * {4'h0, mul_b1};
    mul_p1 <= pipe1;
  end

  vedic_mult_8x8_seq_ctrl #(.MUL_LAT(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(1'b1), .out_p(out_p1),
    .busy(busy1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1),
    .dbg_state(dbg1)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
`ifdef VEDIC_SEQ_SIGNED_EN
    logic signed [15:0] p;
    p = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
    return p;
`else
    return {8'h00, a} * {8'h00, b};
`endif
  endfunction

  // ---------------- scoreboard for DUT 0 ----------------
  logic [15:0] exp_q[$];
  int          acc_cyc_q[$];
  logic        ov_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid0 && !ov_prev) begin
        if (acc_cyc_q.size() > 0) check("latency0", cyc - acc_cyc_q.pop_front(), 4);
        else check("spurious_valid0", 1, 0);
      end
      ov_prev = out_valid0;
      if (out_valid0 && out_ready0) begin
        if (exp_q.size() > 0) check("out_p0", out_p0, exp_q.pop_front());
        else check("spurious_out0", 1, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send0(input logic [7:0] a, input logic [7:0] b, input bit push);
    int n = 0;
    in_a0 = a; in_b0 = b; in_valid0 = 1'b1;
    while (!in_ready0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) check("accept_timeout0", 0, 1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    if (push) begin
      exp_q.push_back(model(a, b));
      acc_cyc_q.push_back(cyc);
    end
  endtask

  task automatic drain0();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge clk); n++;
    end
    check("drain0", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid0();
    int n = 0;
    while (!out_valid0 && n < 50) begin
      @(negedge clk); n++;
    end
    check("valid_seen0", out_valid0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_in_ready", in_ready0, 1);
    check("rst_out_valid", out_valid0, 0);
    check("rst_busy", busy0, 0);
    check("rst_out_p", out_p0, 0);
    check("rst_mul_ab", {mul_a0, mul_b0}, 0);
    check("rst_state", dbg0, 0);

    // basic products, out_ready held high
    out_ready0 = 1'b1;
    send0(8'd200, 8'd150, 1);
    send0(8'd255, 8'd255, 1);
    send0(8'd0, 8'd173, 1);
    drain0();
    check("idle_mul_ab", {mul_a0, mul_b0}, 0);

    // backpressure, plus a pair offered while busy that must be ignored
    out_ready0 = 1'b0;
    send0(8'd255, 8'd255, 1);
    wait_valid0();
    in_a0 = 8'd9; in_b0 = 8'd9; in_valid0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid0, 1);
      check("hold_out_p", out_p0, model(8'd255, 8'd255));
      check("hold_in_ready", in_ready0, 0);
    end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    check("release_idle", in_ready0, 1);
    check("release_valid", out_valid0, 0);
    repeat (8) @(posedge clk);
    #1 check("ignored_pair", busy0, 0);

    // reset during step2 aborts the operation
    send0(8'd200, 8'd150, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_busy", busy0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", in_ready0, 1);
    check("abort_out_valid", out_valid0, 0);
    check("abort_out_p", out_p0, 0);
    check("abort_mul_ab", {mul_a0, mul_b0}, 0);
    rst = 1'b0;
    send0(8'd12, 8'd11, 1);
    drain0();

`ifdef VEDIC_SEQ_SIGNED_EN
    send0(8'hFD, 8'd5, 1);
    send0(8'h80, 8'h80, 1);
    send0(8'd127, 8'h80, 1);
    drain0();
`endif

    // random back-to-back operands
    for (int i = 0; i < 10; i++) begin
      send0(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
    end
    drain0();

    // MUL_LAT = 2 instance
    in_a1 = 8'd17; in_b1 = 8'd19; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    t = cyc;
    n = 0;
    while (!out_valid1 && n < 50) begin
      @(negedge clk); n++;
    end
    check("valid_seen1", out_valid1, 1);
    check("latency1", cyc - t, 12);
    check("out_p1", out_p1, model(8'd17, 8'd19));

    repeat (3) @(posedge clk);
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
